apb_uart_ctrl: RTL and testbench

APB3 completer that drives the loopback UART block from the bus side. It turns register writes into the UART's enable, start and transmit-data controls. It waits for each transfer to finish, then captures the received byte and error flags into sticky status registers. It sits between the APB interconnect and the UART top level, with an optional interrupt output.

---
 rtl/apb_uart_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_apb_uart_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_ctrl.sv
// APB3 completer that drives the loopback UART: control, TX data, sticky RX status.
// Optional registered interrupt output enabled by defining UART_CTRL_IRQ_EN.
module apb_uart_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  uart_enable,
   output logic                  uart_start,
   output logic [7:0]            uart_data_in,
   input  logic [7:0]            uart_data_out,
   input  logic                  uart_busy,
   input  logic                  uart_done,
   input  logic                  uart_error,
   input  logic                  parity_error,
   input  logic                  framing_error,
   output logic                  irq
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_ACTIVE  = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_TXDATA = 2'd1;
   localparam logic [1:0] A_RXDATA = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   state_t     state_q, state_d;
   logic       en_q, en_d;
   logic       ie_q, ie_d;
   logic [7:0] txdata_q, txdata_d;
   logic [7:0] rxdata_q, rxdata_d;
   logic       rxv_q, rxv_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;
   logic       ovr_q, ovr_d;
   logic       done_prev_q, done_prev_d;

   logic       access, wr_en, rd_en;
   logic [1:0] addr;
   logic       busy, ctrl_wr, start_req, ctrl_reject, launch, tx_reject, rx_wr;
   logic       done_rise, capture;
   logic [7:0] rdata;
   logic       unused_ok;

   // Bus outputs are gated by resetn so they snap to idle values while reset is held.
   assign access      = psel & penable & resetn;
   assign wr_en       = access & pwrite;
   assign rd_en       = access & ~pwrite;
   assign addr        = paddr[3:2];
   assign busy        = (state_q != S_IDLE) | uart_busy;
   assign ctrl_wr     = wr_en && (addr == A_CTRL);
   assign start_req   = ctrl_wr & pwdata[1];
   assign ctrl_reject = start_req & busy;
   assign launch      = start_req & pwdata[0] & ~busy;
   assign tx_reject   = wr_en && (addr == A_TXDATA) && (state_q != S_IDLE);
   assign rx_wr       = wr_en && (addr == A_RXDATA);
   assign done_rise   = uart_done & ~done_prev_q;

   assign pready       = 1'b1;
   assign pslverr      = rx_wr | ctrl_reject | tx_reject;
   assign uart_enable  = en_q;
   assign uart_data_in = txdata_q;
   assign unused_ok    = ^{paddr, pwdata, uart_error};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // An EN drop during ACTIVE aborts before a simultaneous done edge is honoured.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (launch) state_d = S_LAUNCH;
         S_LAUNCH:  state_d = S_ACTIVE;
         S_ACTIVE: begin
            if (!en_q)          state_d = S_IDLE;
            else if (done_rise) state_d = S_CAPTURE;
         end
         S_CAPTURE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      uart_start = (state_q == S_LAUNCH);
      capture    = (state_q == S_CAPTURE);
   end

   always_comb begin
      en_d        = en_q;
      ie_d        = ie_q;
      txdata_d    = txdata_q;
      rxdata_d    = rxdata_q;
      rxv_d       = rxv_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      ovr_d       = ovr_q;
      done_prev_d = uart_done;
      if (ctrl_wr && !ctrl_reject) begin
         en_d = pwdata[0];
         ie_d = pwdata[2];
      end
      if (wr_en && (addr == A_TXDATA) && !tx_reject) txdata_d = pwdata[7:0];
      if (rd_en && (addr == A_RXDATA)) rxv_d = 1'b0;
      if (wr_en && (addr == A_STATUS)) begin
         if (pwdata[1]) rxv_d  = 1'b0;
         if (pwdata[2]) perr_d = 1'b0;
         if (pwdata[3]) ferr_d = 1'b0;
         if (pwdata[4]) ovr_d  = 1'b0;
      end
      // Capture is applied last so its sets win over same-cycle clears.
      if (capture) begin
         rxdata_d = uart_data_out;
         if (rxv_q)         ovr_d  = 1'b1;
         rxv_d = 1'b1;
         if (parity_error)  perr_d = 1'b1;
         if (framing_error) ferr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en_q        <= 1'b0;
         ie_q        <= 1'b0;
         txdata_q    <= 8'h00;
         rxdata_q    <= 8'h00;
         rxv_q       <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
         done_prev_q <= 1'b0;
      end else begin
         en_q        <= en_d;
         ie_q        <= ie_d;
         txdata_q    <= txdata_d;
         rxdata_q    <= rxdata_d;
         rxv_q       <= rxv_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
         done_prev_q <= done_prev_d;
      end
   end

   always_comb begin
      rdata = 8'h00;
      case (addr)
         A_CTRL:   rdata = {5'b0, ie_q, 1'b0, en_q};
         A_TXDATA: rdata = txdata_q;
         A_RXDATA: rdata = rxdata_q;
         A_STATUS: rdata = {3'b0, ovr_q, ferr_q, perr_q, rxv_q, busy};
         default:  rdata = 8'h00;
      endcase
      prdata = rd_en ? DATA_WIDTH'(rdata) : '0;
   end

`ifdef UART_CTRL_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = ie_q & (rxv_q | perr_q | ferr_q | ovr_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Directed bench for apb_uart_ctrl: APB driver tasks, a behavioural UART done model,
// and a read-data expectation queue checked with immediate assertions.
module tb_apb_uart_ctrl;

   localparam logic [3:0] A_CTRL   = 4'h0;
   localparam logic [3:0] A_TXDATA = 4'h4;
   localparam logic [3:0] A_RXDATA = 4'h8;
   localparam logic [3:0] A_STATUS = 4'hC;
`ifdef UART_CTRL_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk;
   logic        resetn;
   logic        psel, penable, pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        uart_enable, uart_start;
   logic [7:0]  uart_data_in, uart_data_out;
   logic        uart_busy, uart_done, uart_error, parity_error, framing_error;
   logic        irq;

   int          n_cmp = 0;
   int          n_err = 0;
   int          start_cnt = 0;
   int          s0;
   logic [31:0] exp_q[$];

   apb_uart_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .clk(clk), .resetn(resetn),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .uart_enable(uart_enable), .uart_start(uart_start),
      .uart_data_in(uart_data_in), .uart_data_out(uart_data_out),
      .uart_busy(uart_busy), .uart_done(uart_done), .uart_error(uart_error),
      .parity_error(parity_error), .framing_error(framing_error), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (uart_start === 1'b1) start_cnt <= start_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic exp_err,
                            input string tag);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1;
      check({tag, "_pslverr"}, {31'b0, pslverr}, {31'b0, exp_err});
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      penable = 1'b1;
      #1;
      check(tag, prdata, exp_q.pop_front());
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   // Done held two cycles so data and error flags are stable through the capture cycle.
   task automatic done_pulse(input logic [7:0] d, input logic pe, input logic fe);
      @(negedge clk);
      uart_data_out = d; parity_error = pe; framing_error = fe; uart_done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      uart_done = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_prdata"}, prdata, 32'h0);
      check({tag, "_pslverr"}, {31'b0, pslverr}, 32'h0);
      check({tag, "_pready"}, {31'b0, pready}, 32'h1);
      check({tag, "_enable"}, {31'b0, uart_enable}, 32'h0);
      check({tag, "_start"}, {31'b0, uart_start}, 32'h0);
      check({tag, "_data_in"}, {24'b0, uart_data_in}, 32'h0);
      check({tag, "_irq"}, {31'b0, irq}, 32'h0);
   endtask

   task automatic read_all_zero(input string tag);
      apb_read(A_CTRL, 32'h0, {tag, "_ctrl"});
      apb_read(A_TXDATA, 32'h0, {tag, "_tx"});
      apb_read(A_RXDATA, 32'h0, {tag, "_rx"});
      apb_read(A_STATUS, 32'h0, {tag, "_status"});
   endtask

   initial begin
      resetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
      uart_data_out = 8'h00; uart_busy = 1'b0; uart_done = 1'b0; uart_error = 1'b0;
      parity_error = 1'b0; framing_error = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      resetn = 1'b1;
      read_all_zero("rst0");

      // Basic transfer
      apb_write(A_TXDATA, 32'hA5, 1'b0, "tx_a5");
      check("data_in_a5", {24'b0, uart_data_in}, 32'hA5);
      s0 = start_cnt;
      apb_write(A_CTRL, 32'h3, 1'b0, "ctrl_go1");
      check("start_hi", {31'b0, uart_start}, 32'h1);
      check("enable_hi", {31'b0, uart_enable}, 32'h1);
      @(negedge clk);
      check("start_lo", {31'b0, uart_start}, 32'h0);
      apb_read(A_STATUS, 32'h01, "status_busy");

      // Busy rejection
      apb_write(A_CTRL, 32'h3, 1'b1, "ctrl_busy");
      apb_write(A_TXDATA, 32'h11, 1'b1, "tx_busy");
      apb_write(A_RXDATA, 32'h55, 1'b1, "rx_write");
      apb_read(A_TXDATA, 32'hA5, "tx_kept");
      apb_read(A_CTRL, 32'h1, "ctrl_kept");
      check("start_count1", start_cnt - s0, 32'd1);

      done_pulse(8'hA5, 1'b0, 1'b0);
      apb_read(A_STATUS, 32'h02, "status_rxv");
      check("irq_ie0", {31'b0, irq}, 32'h0);
      apb_read(A_RXDATA, 32'hA5, "rx_a5");
      apb_read(A_STATUS, 32'h00, "status_clr");

      // Overrun and errors
      s0 = start_cnt;
      apb_write(A_TXDATA, 32'h3C, 1'b0, "tx_3c");
      apb_write(A_CTRL, 32'h3, 1'b0, "ctrl_go2");
      done_pulse(8'h3C, 1'b0, 1'b0);
      apb_write(A_CTRL, 32'h3, 1'b0, "ctrl_go3");
      done_pulse(8'hC3, 1'b1, 1'b0);
      check("start_count2", start_cnt - s0, 32'd2);
      apb_read(A_STATUS, 32'h16, "status_ovr");
      apb_write(A_STATUS, 32'h1E, 1'b0, "status_w1c");
      apb_read(A_STATUS, 32'h00, "status_w1c_rd");
      apb_read(A_RXDATA, 32'hC3, "rx_c3");

      // Frame error flag via W1C of one bit only
      apb_write(A_CTRL, 32'h3, 1'b0, "ctrl_go4");
      done_pulse(8'h66, 1'b0, 1'b1);
      apb_write(A_STATUS, 32'h02, 1'b0, "status_w1c_rxv");
      apb_read(A_STATUS, 32'h08, "status_ferr");
      apb_write(A_STATUS, 32'h08, 1'b0, "status_w1c_ferr");

      // Abort
      apb_write(A_CTRL, 32'h3, 1'b0, "ctrl_go5");
      apb_write(A_CTRL, 32'h0, 1'b0, "ctrl_abort");
      @(negedge clk);
      apb_read(A_STATUS, 32'h00, "status_abort");
      done_pulse(8'h77, 1'b1, 1'b1);
      apb_read(A_STATUS, 32'h00, "status_nocap");
      apb_read(A_RXDATA, 32'h66, "rx_nocap");

      // Interrupt
      apb_write(A_CTRL, 32'h7, 1'b0, "ctrl_go_ie");
      @(negedge clk);
      uart_data_out = 8'h5E; uart_done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      uart_done = 1'b0;
      check("irq_pre", {31'b0, irq}, 32'h0);
      @(negedge clk);
      check("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
      apb_read(A_RXDATA, 32'h5E, "rx_5e");
      check("irq_hold", {31'b0, irq}, {31'b0, IRQ_ON});
      @(negedge clk);
      check("irq_clr", {31'b0, irq}, 32'h0);

      // Reset mid-transfer
      apb_write(A_TXDATA, 32'h5A, 1'b0, "tx_5a");
      apb_write(A_CTRL, 32'h3, 1'b0, "ctrl_go6");
      check("start_pre_rst", {31'b0, uart_start}, 32'h1);
      resetn = 1'b0;
      #1;
      check_reset_outputs("rst1");
      @(negedge clk);
      check_reset_outputs("rst1_hold");
      resetn = 1'b1;
      read_all_zero("rst1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
